// File: rtl/mem_copy_engine.sv
// mem_copy_engine: fills or forward-copies byte ranges in the 256-byte data memory, summing every byte written
// Ports: clk/reset (sync, active-high); start/op/src_addr/dst_addr/len/fill_value form the request;
// busy/done/checksum report progress; mem_write_en/mem_address/mem_wdata drive the memory, mem_rdata is its combinational read.
module mem_copy_engine (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       op,
    input  logic [7:0] src_addr,
    input  logic [7:0] dst_addr,
    input  logic [7:0] len,
    input  logic [7:0] fill_value,
    output logic       busy,
    output logic       done,
    output logic [7:0] checksum,
    output logic       mem_write_en,
    output logic [7:0] mem_address,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);
    localparam logic OP_FILL = 1'b1;
    typedef enum logic [2:0] {IDLE, READ, WRITE, FILL, DONE} state_t;
    state_t state, next_state;
    logic [7:0] src_ptr, dst_ptr, count, value, data_buf;
    logic writing;
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            src_ptr  <= '0;
            dst_ptr  <= '0;
            count    <= '0;
            value    <= '0;
            data_buf <= '0;
            checksum <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (start) begin
                    src_ptr  <= src_addr;
                    dst_ptr  <= dst_addr;
                    count    <= len;
                    value    <= fill_value;
                    checksum <= '0;
                end
                READ: data_buf <= mem_rdata;
                // mem_wdata already carries the byte being written in both WRITE and FILL
                WRITE, FILL: begin
                    src_ptr  <= src_ptr + 8'd1;
                    dst_ptr  <= dst_ptr + 8'd1;
                    count    <= count - 8'd1;
                    checksum <= checksum + mem_wdata;
                end
                default: ;
            endcase
        end
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (len == 8'd0) ? DONE : (op == OP_FILL) ? FILL : READ;
            READ:    next_state = WRITE;
            WRITE:   next_state = (count == 8'd1) ? DONE : READ;
            FILL:    next_state = (count == 8'd1) ? DONE : FILL;
            default: next_state = IDLE;
        endcase
        writing      = (state == WRITE) || (state == FILL);
        busy         = writing || (state == READ);
        done         = (state == DONE);
        // gated by reset so an aborted operation never commits a write
        mem_write_en = writing && !reset;
        mem_address  = (state == READ) ? src_ptr : writing ? dst_ptr : 8'h00;
        mem_wdata    = (state == WRITE) ? data_buf : (state == FILL) ? value : 8'h00;
    end
endmodule
